// File: rtl/mem_boot_arb_pkg.sv
// Shared encodings for the boot arbiter: host command opcodes, lifecycle states,
// and the core read/write polarity.
package mem_boot_arb_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_RUN  = 2'd1,
    OP_STOP = 2'd2,
    OP_DUMP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DUMP = 2'd3
  } state_e;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/mem_boot_arb_run_watchdog.sv
// RUN-phase cycle counter; raises expire in the last permitted RUN cycle.
// RUN_MAX of 0 disables the limit entirely.
module run_watchdog #(
  parameter int RUN_MAX = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (RUN_MAX > 1) ? $clog2(RUN_MAX) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((RUN_MAX > 0) ? (RUN_MAX - 1) : 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (RUN_MAX != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/mem_boot_arb.sv
// Memory-bus owner and core lifecycle sequencer: host LOAD/DUMP of the program
// memory while the core is held in clear, then hands the bus to the core in RUN.
module mem_boot_arb
  import mem_boot_arb_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 16,
  parameter int RUN_MAX = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_adrs,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          core_clr,
  input  logic          core_rw,
  input  logic [AW-1:0] core_adrs,
  input  logic [7:0]    core_dout,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          running,
  output logic          timeout
);

  state_e        state, state_next;
  logic [AW-1:0] ptr, ptr_next;
  logic [AW-1:0] cnt, cnt_next;
  logic          timeout_next;
  logic          cmd_acc;
  logic          expire;
  op_e           op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign cmd_acc   = cmd_valid && cmd_ready;
  assign wr_ready  = (state == ST_LOAD);
  assign running   = (state == ST_RUN);
  assign core_clr  = (state != ST_RUN);

  run_watchdog #(
    .RUN_MAX(RUN_MAX)
  ) u_run_watchdog (
    .clk   (clk),
    .clr   (clr),
    .clear (state != ST_RUN),
    .enable(state == ST_RUN),
    .expire(expire)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      rd_valid <= (state == ST_DUMP);
      timeout  <= timeout_next;
      if (state == ST_DUMP) begin
        rd_data <= mem_rdata;
      end
    end
  end

  // Any accepted command clears timeout; a same-cycle expiry still sets it.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    cnt_next     = cnt;
    timeout_next = timeout;
    if (cmd_acc) begin
      timeout_next = 1'b0;
    end
    case (state)
      ST_IDLE: begin
        if (cmd_acc) begin
          case (op)
            OP_LOAD: begin
              ptr_next   = cmd_adrs;
              cnt_next   = cmd_len;
              state_next = ST_LOAD;
            end
            OP_DUMP: begin
              ptr_next   = cmd_adrs;
              cnt_next   = cmd_len;
              state_next = ST_DUMP;
            end
            OP_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD: begin
        if (wr_valid) begin
          ptr_next = ptr + 1'b1;
          if (cnt == '0) begin
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt - 1'b1;
          end
        end
      end
      ST_DUMP: begin
        ptr_next = ptr + 1'b1;
        if (cnt == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_RUN: begin
        if (cmd_acc && (op == OP_STOP)) begin
          state_next = ST_IDLE;
        end else if (expire) begin
          state_next   = ST_IDLE;
          timeout_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_adrs  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      ST_LOAD: begin
        mem_adrs  = ptr;
        mem_wdata = wr_data;
        mem_we    = wr_valid;
      end
      ST_DUMP: begin
        mem_adrs = ptr;
      end
      ST_RUN: begin
        mem_adrs  = core_adrs;
        mem_wdata = {{(DW-8){1'b0}}, core_dout};
        mem_we    = (core_rw != RW_READ);
      end
      default: begin
        mem_adrs = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_boot_arb.sv
// Scoreboard bench for mem_boot_arb: stimulus pushes expected memory writes and
// dump words; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_boot_arb;

  localparam int RUN_MAX = 8;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [7:0]  cmd_adrs = 8'd0;
  logic [7:0]  cmd_len = 8'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = 16'd0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        core_clr;
  logic        core_rw = 1'b1;
  logic [7:0]  core_adrs = 8'd0;
  logic [7:0]  core_dout = 8'd0;
  logic [7:0]  mem_adrs;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        running;
  logic        timeout;

  typedef struct {
    logic [7:0]  adrs;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [15:0] mem[256];
  logic [15:0] ref_mem[256];
  logic        mem_zero = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;
  wr_t         mon_wr;
  logic [15:0] mon_rd;

  always #5 clk = ~clk;

  mem_boot_arb #(
    .AW(8),
    .DW(16),
    .RUN_MAX(RUN_MAX)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_adrs (cmd_adrs),
    .cmd_len  (cmd_len),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .core_clr (core_clr),
    .core_rw  (core_rw),
    .core_adrs(core_adrs),
    .core_dout(core_dout),
    .mem_adrs (mem_adrs),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .running  (running),
    .timeout  (timeout)
  );

  // Behavioural 256x16 memory: combinational read, write at the clock edge.
  assign mem_rdata = mem[mem_adrs];

  always @(posedge clk) begin
    if (mem_zero) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (mem_we) begin
      mem[mem_adrs] <= mem_wdata;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: got event, expected none", name);
  endtask

  always @(negedge clk) begin
    if (!clr && mem_we) begin
      if (exp_wr.size() == 0) begin
        flag_fail("unexpected_mem_write");
      end else begin
        mon_wr = exp_wr.pop_front();
        check_output("wr_adrs", {24'd0, mem_adrs}, {24'd0, mon_wr.adrs});
        check_output("wr_data", {16'd0, mem_wdata}, {16'd0, mon_wr.data});
      end
    end
    if (!clr && rd_valid) begin
      if (exp_rd.size() == 0) begin
        flag_fail("unexpected_rd_valid");
      end else begin
        mon_rd = exp_rd.pop_front();
        check_output("rd_data", {16'd0, rd_data}, {16'd0, mon_rd});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] adrs,
                           input logic [7:0] len);
    int waited = 0;
    while (!cmd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!cmd_ready) flag_fail("cmd_ready_wait_expired");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adrs  = adrs;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  // base != 0 gives an incrementing word pattern, otherwise random words.
  task automatic do_load(input logic [7:0] adrs, input logic [7:0] len,
                         input logic [15:0] base);
    logic [7:0]  a;
    logic [15:0] d;
    issue_cmd(2'd0, adrs, len);
    check_output("load_wr_ready", {31'd0, wr_ready}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        wr_valid = 1'b0;
        step();
      end
      a = adrs + 8'(i);
      d = (base != 16'd0) ? base + 16'(i) : 16'($urandom);
      exp_wr.push_back('{adrs: a, data: d});
      ref_mem[a] = d;
      wr_valid = 1'b1;
      wr_data  = d;
      if (i < 4) check_output("load_core_clr", {31'd0, core_clr}, 32'd1);
      step();
    end
    wr_valid = 1'b0;
    check_output("load_done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_output("load_done_wr_ready", {31'd0, wr_ready}, 32'd0);
    check_output("load_done_core_clr", {31'd0, core_clr}, 32'd1);
  endtask

  task automatic do_dump(input logic [7:0] adrs, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) exp_rd.push_back(ref_mem[8'(adrs + 8'(i))]);
    issue_cmd(2'd3, adrs, len);
    check_output("dump_cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      step();
      if (i == 0 || i == int'(len)) check_output("dump_rd_valid", {31'd0, rd_valid}, 32'd1);
    end
    check_output("dump_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    step();
    check_output("dump_rd_valid_end", {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic do_stop();
    core_rw = 1'b1;
    issue_cmd(2'd2, 8'd0, 8'd0);
    check_output("stop_running", {31'd0, running}, 32'd0);
    check_output("stop_core_clr", {31'd0, core_clr}, 32'd1);
    check_output("stop_timeout", {31'd0, timeout}, 32'd0);
  endtask

  // Runs n cycles (< RUN_MAX-1) of random core traffic, then STOPs.
  task automatic do_run_random(input int n);
    issue_cmd(2'd1, 8'd0, 8'd0);
    for (int c = 0; c < n; c++) begin
      core_rw   = 1'($urandom_range(0, 1));
      core_adrs = 8'($urandom);
      core_dout = 8'($urandom);
      if (!core_rw) begin
        exp_wr.push_back('{adrs: core_adrs, data: {8'h00, core_dout}});
        ref_mem[core_adrs] = {8'h00, core_dout};
      end
      check_output("run_running", {31'd0, running}, 32'd1);
      step();
    end
    do_stop();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check_output({tag, "_wr_ready"}, {31'd0, wr_ready}, 32'd0);
    check_output({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
    check_output({tag, "_rd_data"}, {16'd0, rd_data}, 32'd0);
    check_output({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_output({tag, "_mem_adrs"}, {24'd0, mem_adrs}, 32'd0);
    check_output({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check_output({tag, "_running"}, {31'd0, running}, 32'd0);
    check_output({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check_output({tag, "_core_clr"}, {31'd0, core_clr}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [15:0] d;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    step();
    step();
    check_reset_values("reset");
    mem_zero = 1'b0;
    clr = 1'b0;
    step();

    do_load(8'h10, 8'd2, 16'hA001);
    do_load(8'hFE, 8'd3, 16'd0);
    do_dump(8'h10, 8'd2);
    do_dump(8'hFE, 8'd3);

    // Directed core write during RUN.
    issue_cmd(2'd1, 8'd0, 8'd0);
    check_output("run_core_clr", {31'd0, core_clr}, 32'd0);
    core_rw   = 1'b0;
    core_adrs = 8'h20;
    core_dout = 8'h5A;
    exp_wr.push_back('{adrs: 8'h20, data: 16'h005A});
    ref_mem[8'h20] = 16'h005A;
    step();
    core_rw = 1'b1;
    issue_cmd(2'd0, 8'h00, 8'd0);
    check_output("run_ignores_load", {31'd0, running}, 32'd1);
    do_stop();
    do_dump(8'h20, 8'd0);

    // Watchdog expiry with no STOP.
    issue_cmd(2'd1, 8'd0, 8'd0);
    for (int c = 0; c < RUN_MAX; c++) begin
      check_output("wd_running", {31'd0, running}, 32'd1);
      step();
    end
    check_output("wd_expired_running", {31'd0, running}, 32'd0);
    check_output("wd_timeout_set", {31'd0, timeout}, 32'd1);
    check_output("wd_core_clr", {31'd0, core_clr}, 32'd1);
    step();
    step();
    check_output("wd_timeout_sticky", {31'd0, timeout}, 32'd1);
    for (int i = 0; i < 2; i++) exp_rd.push_back(ref_mem[8'h10 + 8'(i)]);
    issue_cmd(2'd3, 8'h10, 8'd1);
    check_output("wd_timeout_cleared", {31'd0, timeout}, 32'd0);
    step();
    step();
    step();

    // STOP on the expiry cycle wins.
    issue_cmd(2'd1, 8'd0, 8'd0);
    for (int c = 0; c < RUN_MAX - 1; c++) step();
    check_output("wd_last_cycle_running", {31'd0, running}, 32'd1);
    do_stop();

    // Reset in the middle of a LOAD.
    issue_cmd(2'd0, 8'h80, 8'd3);
    d = 16'($urandom);
    exp_wr.push_back('{adrs: 8'h80, data: d});
    ref_mem[8'h80] = d;
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b1;
    wr_data  = ~d;
    clr = 1'b1;
    #1;
    check_reset_values("midload");
    wr_valid = 1'b0;
    step();
    clr = 1'b0;
    step();
    do_dump(8'h80, 8'd3);

    // Full 256-word load across the wrap.
    do_load(8'($urandom), 8'hFF, 16'd0);
    do_dump(8'h00, 8'hFF);

    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0:       do_load(8'($urandom), 8'($urandom_range(0, 7)), 16'd0);
        1:       do_dump(8'($urandom), 8'($urandom_range(0, 7)));
        default: do_run_random(int'($urandom_range(1, RUN_MAX - 2)));
      endcase
    end

    step();
    step();
    check_output("exp_wr_drained", exp_wr.size(), 32'd0);
    check_output("exp_rd_drained", exp_rd.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
